// File: rtl/plot_arbiter.sv
// plot_arbiter: merges NCH pixel writers into one registered, clipped plot port
module plot_arbiter #(
  parameter int    NCH            = 3,
  parameter string RESOLUTION     = "160x120",
  parameter int    COLOR_DEPTH    = 9,
  parameter int    FIXED_PRIORITY = 0,
  localparam int   NX   = RESOLUTION == "640x480" ? 10 : RESOLUTION == "320x240" ? 9 : 8,
  localparam int   NY   = RESOLUTION == "640x480" ? 9 : RESOLUTION == "320x240" ? 8 : 7,
  localparam int   XMAX = RESOLUTION == "640x480" ? 640 : RESOLUTION == "320x240" ? 320 : 160,
  localparam int   YMAX = RESOLUTION == "640x480" ? 480 : RESOLUTION == "320x240" ? 240 : 120
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET,
  input  logic [NCH-1:0]             ch_valid,
  output logic [NCH-1:0]             ch_ready,
  input  logic [NCH*NX-1:0]          ch_x,
  input  logic [NCH*NY-1:0]          ch_y,
  input  logic [NCH*COLOR_DEPTH-1:0] ch_color,
  input  logic                       stall,
  output logic [NX-1:0]              VGA_X,
  output logic [NY-1:0]              VGA_Y,
  output logic [23:0]                VGA_COLOR,
  output logic                       plot,
  output logic [2:0]                 VGA_CH,
  output logic [15:0]                drop_count
);
  localparam int C = COLOR_DEPTH / 3;
  logic [NX-1:0] xs [8];
  logic [NY-1:0] ys [8];
  logic [23:0]   cs [8];
  logic [7:0]    v8;
  logic [2:0]    rr_ptr, start, gnt;
  logic          found, free, xfer, clip;
  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < NCH) begin : g_used
      assign xs[i] = ch_x[i*NX +: NX];
      assign ys[i] = ch_y[i*NY +: NY];
      for (genvar k = 0; k < 3; k++) begin : g_comp
        for (genvar j = 0; j < 8; j++) begin : g_bit
          assign cs[i][8*k + 7 - j] = ch_color[i*COLOR_DEPTH + C*k + C - 1 - (j % C)];
        end
      end
    end else begin : g_pad
      assign xs[i] = '0;
      assign ys[i] = '0;
      assign cs[i] = '0;
    end
  end
  assign v8    = 8'(ch_valid);
  assign free  = !plot || !stall;
  assign start = FIXED_PRIORITY != 0 ? 3'(NCH - 1) : rr_ptr;
  // Search from start+1 upward with wrap; the loop runs backwards so the nearest valid channel wins
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int k = NCH; k >= 1; k--)
      if (v8[3'((int'(start) + k) % NCH)]) begin
        found = 1'b1;
        gnt = 3'((int'(start) + k) % NCH);
      end
  end
  assign xfer     = free && found;
  assign clip     = xs[gnt] >= NX'(XMAX) || ys[gnt] >= NY'(YMAX);
  assign ch_ready = NCH'(8'(xfer && !RESET) << gnt);
  // Output register: loads on an unclipped transfer, clears plot when idle, freezes while stalled
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) begin
      plot <= 1'b0;
      VGA_X <= '0;
      VGA_Y <= '0;
      VGA_COLOR <= '0;
      VGA_CH <= '0;
      drop_count <= '0;
      rr_ptr <= 3'(NCH - 1);
    end else if (free) begin
      plot <= xfer && !clip;
      if (xfer) rr_ptr <= gnt;
      if (xfer && !clip) begin
        VGA_X <= xs[gnt];
        VGA_Y <= ys[gnt];
        VGA_COLOR <= cs[gnt];
        VGA_CH <= gnt;
      end
      if (xfer && clip && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: scoreboard bench for plot_arbiter (round-robin and fixed-priority instances)
module tb_plot_arbiter;
  logic clk = 1'b0;
  logic RESET;
  logic [2:0] ch_valid, ch_ready;
  logic [23:0] ch_x;
  logic [20:0] ch_y;
  logic [26:0] ch_color;
  logic stall;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [23:0] VGA_COLOR;
  logic plot;
  logic [2:0] VGA_CH;
  logic [15:0] drop_count;
  logic [2:0] f_valid, f_ready;
  logic [23:0] f_xin;
  logic [20:0] f_yin;
  logic [26:0] f_cin;
  logic f_stall;
  logic [7:0] f_x;
  logic [6:0] f_y;
  logic [23:0] f_color;
  logic f_plot;
  logic [2:0] f_ch;
  logic [15:0] f_drop;
  logic [41:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] bcol_in [3] = '{9'h1FF, 9'h000, 9'h049};
  logic [23:0] bcol [3] = '{24'hFFFFFF, 24'h000000, 24'h242424};

  always #5 clk = ~clk;

  plot_arbiter #(.NCH(3)) dut (
    .CLOCK_50(clk), .RESET(RESET), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_x(ch_x), .ch_y(ch_y), .ch_color(ch_color), .stall(stall),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot(plot),
    .VGA_CH(VGA_CH), .drop_count(drop_count)
  );

  plot_arbiter #(.NCH(3), .FIXED_PRIORITY(1)) fdut (
    .CLOCK_50(clk), .RESET(RESET), .ch_valid(f_valid), .ch_ready(f_ready),
    .ch_x(f_xin), .ch_y(f_yin), .ch_color(f_cin), .stall(f_stall),
    .VGA_X(f_x), .VGA_Y(f_y), .VGA_COLOR(f_color), .plot(f_plot),
    .VGA_CH(f_ch), .drop_count(f_drop)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setp(input int c, input logic [7:0] x, input logic [6:0] y, input logic [8:0] col);
    ch_x[c*8 +: 8] = x;
    ch_y[c*7 +: 7] = y;
    ch_color[c*9 +: 9] = col;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (RESET === 1'b0 && plot === 1'b1 && stall === 1'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pixel: got %0h expected none", {VGA_X, VGA_Y, VGA_COLOR, VGA_CH});
      end else begin
        logic [41:0] e;
        e = exp_q.pop_front();
        if ({VGA_X, VGA_Y, VGA_COLOR, VGA_CH} !== e) begin
          n_err++;
          $display("FAIL pixel: got %0h expected %0h", {VGA_X, VGA_Y, VGA_COLOR, VGA_CH}, e);
        end
      end
    end

  initial begin
    RESET = 1'b1;
    ch_valid = 3'b111;
    ch_x = '0;
    ch_y = '0;
    ch_color = '0;
    stall = 1'b0;
    f_valid = '0;
    f_xin = '0;
    f_yin = '0;
    f_cin = '0;
    f_stall = 1'b0;
    tick;
    tick;
    chk("reset_outputs", {plot, VGA_X, VGA_Y, VGA_COLOR, VGA_CH, drop_count}, '0);
    chk("reset_ready", ch_ready, 3'b000);
    ch_valid = '0;
    RESET = 1'b0;
    // single write
    setp(0, 8'd10, 7'd20, 9'h1C5);
    ch_valid = 3'b001;
    #1 chk("single_ready", ch_ready, 3'b001);
    exp_q.push_back({8'd10, 7'd20, 24'hFF00B6, 3'd0});
    tick;
    ch_valid = '0;
    tick;
    chk("single_plot_clear", plot, 1'b0);
    // round-robin after a fresh reset
    RESET = 1'b1;
    #1 RESET = 1'b0;
    for (int c = 0; c < 3; c++) setp(c, 8'(c + 1), 7'(c + 4), bcol_in[c]);
    ch_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_ready", ch_ready, 3'b001 << (i % 3));
      exp_q.push_back({8'(i % 3 + 1), 7'(i % 3 + 4), bcol[i % 3], 3'(i % 3)});
      @(posedge clk);
    end
    #1 ch_valid = '0;
    tick;
    // stall freezes the stage and blocks ch1
    setp(0, 8'd7, 7'd8, 9'h0B8);
    ch_valid = 3'b001;
    exp_q.push_back({8'd7, 7'd8, 24'h49FF00, 3'd0});
    tick;
    setp(1, 8'd159, 7'd119, 9'h124);
    ch_valid = 3'b010;
    stall = 1'b1;
    exp_q.push_back({8'd159, 7'd119, 24'h929292, 3'd1});
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", ch_ready, 3'b000);
      chk("stall_hold", {plot, VGA_X, VGA_Y, VGA_COLOR, VGA_CH}, {1'b1, 8'd7, 7'd8, 24'h49FF00, 3'd0});
      @(posedge clk);
    end
    #1 stall = 1'b0;
    #1 chk("unstall_ready", ch_ready, 3'b010);
    // clipping on x then y, then saturation
    @(posedge clk);
    #1 setp(0, 8'd160, 7'd0, 9'h0);
    ch_valid = 3'b001;
    #1 chk("clip_x_ready", ch_ready, 3'b001);
    tick;
    chk("clip_x", {plot, drop_count}, {1'b0, 16'd1});
    setp(0, 8'd0, 7'd120, 9'h0);
    #1 chk("clip_y_ready", ch_ready, 3'b001);
    tick;
    chk("clip_y", {plot, drop_count}, {1'b0, 16'd2});
    setp(0, 8'd200, 7'd0, 9'h0);
    repeat (65533) @(posedge clk);
    #1 chk("drop_reach_max", drop_count, 16'hFFFF);
    repeat (4) tick;
    chk("drop_saturate", {plot, drop_count, ch_ready}, {1'b0, 16'hFFFF, 3'b001});
    ch_valid = '0;
    tick;
    // fixed priority instance
    f_xin = {8'd3, 8'd0, 8'd1};
    f_valid = 3'b101;
    for (int i = 0; i < 4; i++) begin
      #1 chk("fp_ready0", f_ready, 3'b001);
      tick;
      chk("fp_out0", {f_plot, f_ch, f_x}, {1'b1, 3'd0, 8'd1});
    end
    f_valid = 3'b100;
    #1 chk("fp_ready2", f_ready, 3'b100);
    tick;
    chk("fp_out2", {f_plot, f_ch, f_x}, {1'b1, 3'd2, 8'd3});
    f_valid = '0;
    // asynchronous reset while stalled with a pixel held
    setp(0, 8'd1, 7'd1, 9'h1C5);
    ch_valid = 3'b001;
    exp_q.push_back({8'd1, 7'd1, 24'hFF00B6, 3'd0});
    tick;
    ch_valid = '0;
    stall = 1'b1;
    #1 chk("pre_reset_plot", plot, 1'b1);
    #1 RESET = 1'b1;
    exp_q.delete();
    setp(0, 8'd3, 7'd4, 9'h038);
    ch_valid = 3'b111;
    #1 chk("async_reset", {plot, VGA_X, VGA_Y, VGA_COLOR, VGA_CH, drop_count}, '0);
    chk("reset_ready_hold", ch_ready, 3'b000);
    RESET = 1'b0;
    stall = 1'b0;
    #2 chk("post_reset_grant", ch_ready, 3'b001);
    exp_q.push_back({8'd3, 7'd4, 24'h00FF00, 3'd0});
    tick;
    ch_valid = '0;
    tick;
    tick;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
